board_clk_rst_gen: RTL

Board-level clock, reset and heartbeat generator for the FPGA top wrapper. It replaces the fixed divide-by-10 user clock and the single LED blinker. It derives a programmable-ratio user clock plus a matching single-cycle clock enable from the board clock, and holds the SoC reset low for a fixed number of user-clock periods. It also drives NUM_LED phase-staggered heartbeat outputs. Sits between the board oscillator and the pulpino_top clk/rst_n/LED pins.

---
 rtl/board_clk_rst_gen.sv | 135 +++++++++++++
 1 files changed

// File: rtl/board_clk_rst_gen.sv
// rtl/board_clk_rst_gen.sv - board clock divider, user reset hold and staggered heartbeat
// Optional feature macro: BOARD_CLKGEN_RERESET_EN (re-hold usr_rst_n_o on every ratio apply)
module board_clk_rst_gen #(
  parameter int CLK_HZ   = 50000000,
  parameter int HB_HZ    = 1,
  parameter int NUM_LED  = 4,
  parameter int DIV_W    = 8,
  parameter int DEF_DIV  = 10,
  parameter int RST_HOLD = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [DIV_W-1:0]   div_i,
  input  logic               div_load_i,
  output logic               div_busy_o,
  output logic               usr_clk_o,
  output logic               usr_clk_en_o,
  output logic               usr_rst_n_o,
  output logic [NUM_LED-1:0] hb_o
);

  localparam int HB_PERIOD = CLK_HZ / HB_HZ;
  localparam int HB_STEP   = HB_PERIOD / NUM_LED;
  localparam int HB_HALF   = HB_PERIOD / 2;
  localparam int HB_W      = $clog2(HB_PERIOD);
  localparam int HOLD_W    = $clog2(RST_HOLD + 1);

  logic [DIV_W-1:0]   cnt_q, cnt_d;
  logic [DIV_W-1:0]   d_q, d_d;
  logic [DIV_W-1:0]   pend_q, pend_d;
  logic               busy_q, busy_d;
  logic               usr_clk_q, usr_clk_d;
  logic               usr_en_q, usr_en_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic               usr_rst_n_q, usr_rst_n_d;
  logic [HB_W-1:0]    hb_cnt_q, hb_cnt_d;
  logic [NUM_LED-1:0] hb_q, hb_d;
  logic [DIV_W-1:0]   div_req;
  logic               wrap;

  // Divider counter, ratio register and pending-ratio handoff; new ratio only lands at a wrap
  always_comb begin
    div_req   = (div_i < DIV_W'(2)) ? DIV_W'(2) : div_i;
    wrap      = (cnt_q == d_q - DIV_W'(1));
    cnt_d     = wrap ? '0 : cnt_q + DIV_W'(1);
    d_d       = d_q;
    pend_d    = pend_q;
    busy_d    = busy_q;
    usr_clk_d = (cnt_q < (d_q >> 1));
    usr_en_d  = (cnt_q == '0);
    if (wrap) begin
      if (div_load_i) begin
        d_d = div_req;
      end else if (busy_q) begin
        d_d = pend_q;
      end
      busy_d = 1'b0;
    end else if (div_load_i) begin
      pend_d = div_req;
      busy_d = 1'b1;
    end
  end

`ifdef BOARD_CLKGEN_RERESET_EN
  logic apply;
  assign apply = wrap && (div_load_i || busy_q);
`endif

  // Reset hold: count usr_clk rises (cnt==0 edges) and release after RST_HOLD full periods
  always_comb begin
    hold_d      = hold_q;
    usr_rst_n_d = usr_rst_n_q;
    if (cnt_q == '0) begin
      if (hold_q == HOLD_W'(RST_HOLD)) begin
        usr_rst_n_d = 1'b1;
      end else begin
        hold_d = hold_q + HOLD_W'(1);
      end
    end
`ifdef BOARD_CLKGEN_RERESET_EN
    if (apply) begin
      hold_d      = '0;
      usr_rst_n_d = 1'b0;
    end
`endif
  end

  // Heartbeat phase counter, free-running and unrelated to the divider
  always_comb begin
    hb_cnt_d = (hb_cnt_q == HB_W'(HB_PERIOD - 1)) ? '0 : hb_cnt_q + HB_W'(1);
  end

  for (genvar g = 0; g < NUM_LED; g++) begin : g_hb
    localparam logic [31:0] OFS = 32'(g * HB_STEP);
    logic [31:0] ph_sum;
    logic [31:0] ph;
    assign ph_sum  = 32'(hb_cnt_q) + OFS;
    assign ph      = (ph_sum >= 32'(HB_PERIOD)) ? ph_sum - 32'(HB_PERIOD) : ph_sum;
    assign hb_d[g] = (ph < 32'(HB_HALF));
  end

  // State register; every output comes straight from a flop
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      d_q         <= DIV_W'(DEF_DIV);
      pend_q      <= '0;
      busy_q      <= 1'b0;
      usr_clk_q   <= 1'b0;
      usr_en_q    <= 1'b0;
      hold_q      <= '0;
      usr_rst_n_q <= 1'b0;
      hb_cnt_q    <= '0;
      hb_q        <= '0;
    end else begin
      cnt_q       <= cnt_d;
      d_q         <= d_d;
      pend_q      <= pend_d;
      busy_q      <= busy_d;
      usr_clk_q   <= usr_clk_d;
      usr_en_q    <= usr_en_d;
      hold_q      <= hold_d;
      usr_rst_n_q <= usr_rst_n_d;
      hb_cnt_q    <= hb_cnt_d;
      hb_q        <= hb_d;
    end
  end

  assign div_busy_o   = busy_q;
  assign usr_clk_o    = usr_clk_q;
  assign usr_clk_en_o = usr_en_q;
  assign usr_rst_n_o  = usr_rst_n_q;
  assign hb_o         = hb_q;

endmodule
